// File: rtl/wb_initiator_pkg.sv
// Shared types for the single-outstanding Wishbone pipelined initiator.
package wb_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    GAP,
    RESP
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_ERR     = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;
  localparam status_t ST_RETRY   = 2'b11;

endpackage

// File: rtl/wb_initiator_tmo_counter.sv
// Bus-cycle watchdog: counts cycles while enabled, flags the TIMEOUT-th cycle.
module wb_tmo_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Asserted during the last permitted cycle so the abort lands on its closing edge.
  assign expired = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone pipelined master: one command in, one bus cycle, one response out.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic [1:0]              rsp_status_o,
  output logic                    busy_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t                state, state_next;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [RW-1:0]         retry_cnt;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_next;
  status_t               rsp_status_q, rsp_status_next;
  logic                  load_rsp, retry_inc, accept, live, in_bus, tmo_expired;

  assign in_bus = (state == ADDR) || (state == DATA);
  assign accept = (state == IDLE) && cmd_valid_i;
  // Terminations only count once the slave has taken the strobe.
  assign live   = ((state == ADDR) && !wb_stall_i) || (state == DATA);

  wb_tmo_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (tmo_expired)
  );

  always_comb begin
    state_next      = state;
    load_rsp        = 1'b0;
    retry_inc       = 1'b0;
    rsp_dat_next    = '0;
    rsp_status_next = ST_OK;
    case (state)
      IDLE: begin
        if (cmd_valid_i) state_next = ADDR;
      end
      ADDR, DATA: begin
        if (live && wb_err_i) begin
          state_next      = RESP;
          load_rsp        = 1'b1;
          rsp_status_next = ST_ERR;
        end else if (live && wb_rty_i) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            state_next = GAP;
            retry_inc  = 1'b1;
          end else begin
            state_next      = RESP;
            load_rsp        = 1'b1;
            rsp_status_next = ST_RETRY;
          end
        end else if (live && wb_ack_i) begin
          state_next      = RESP;
          load_rsp        = 1'b1;
          rsp_status_next = ST_OK;
          rsp_dat_next    = we_q ? '0 : wb_dat_i;
        end else if (tmo_expired) begin
          state_next      = RESP;
          load_rsp        = 1'b1;
          rsp_status_next = ST_TIMEOUT;
        end else if ((state == ADDR) && !wb_stall_i) begin
          state_next = DATA;
        end
      end
      GAP: state_next = ADDR;
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      retry_cnt    <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q      <= cmd_we_i;
        adr_q     <= cmd_adr_i;
        dat_q     <= cmd_dat_i;
        sel_q     <= cmd_sel_i;
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
      if (load_rsp) begin
        rsp_dat_q    <= rsp_dat_next;
        rsp_status_q <= rsp_status_next;
      end
    end
  end

  assign cmd_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign rsp_valid_o  = (state == RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = in_bus;
  assign wb_stb_o     = (state == ADDR);
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: scripted slave timelines derived per attempt, checked every cycle.
module tb_wb_initiator;

  localparam int TMO = 8;
  localparam int MR  = 3;
  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy, wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty, wb_stall;

  wb_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO),
    .MAX_RETRY (MR)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status), .busy_o(busy),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
    .wb_stall_i(wb_stall), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit cyc, stb, stall, ack, err, rty, resp, ready;
    logic [31:0] dat;
  } ent_t;

  ent_t plan[$];
  int          att_stall[MR+1], att_delay[MR+1], att_kind[MR+1];
  bit          att_extra[MR+1];
  logic [31:0] att_dat[MR+1];
  logic [1:0]  m_status;
  logic [31:0] m_dat;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit exp_cyc, exp_stb, exp_rv, exp_rdy, exp_busy, cur_we, prev_stb;
  logic [31:0] cur_adr, cur_dat, exp_rdat, obs_dat;
  logic [3:0]  cur_sel;
  logic [1:0]  exp_rstat, obs_stat;
  int stb_phases, cyc_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc", 32'(wb_cyc), 32'(exp_cyc));
      chk("stb", 32'(wb_stb), 32'(exp_stb));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_cyc) begin
        chk("wb_adr", wb_adr, cur_adr);
        chk("wb_we", 32'(wb_we), 32'(cur_we));
        chk("wb_sel", 32'(wb_sel), 32'(cur_sel));
        if (cur_we) chk("wb_dat", wb_dat_o, cur_dat);
      end
      if (exp_rv) begin
        chk("rsp_dat", rsp_dat, exp_rdat);
        chk("rsp_status", 32'(rsp_status), 32'(exp_rstat));
        obs_dat  = rsp_dat;
        obs_stat = rsp_status;
      end
      if (wb_stb && !prev_stb) stb_phases++;
      if (wb_cyc) cyc_cycles++;
      prev_stb = wb_stb;
    end
  end

  function automatic ent_t blank();
    ent_t e;
    e = '0;
    e.dat   = $urandom;
    e.stall = 1'($urandom_range(0, 1));
    e.ready = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic ent_t noisy(ent_t e);
    logic [2:0] v;
    v = 3'($urandom_range(1, 7));
    e.ack = v[0]; e.err = v[1]; e.rty = v[2];
    return e;
  endfunction

  // Expand per-attempt slave behaviour into a cycle timeline plus the expected outcome.
  task automatic build_plan(input bit we, input int rdly);
    int a, term, len;
    bit done;
    ent_t e;
    plan.delete();
    a = 0; done = 0; m_dat = '0; m_status = 2'b00;
    while (!done) begin
      term = (att_kind[a] == K_NONE) ? 1000 : att_stall[a] + att_delay[a];
      len  = (term < TMO) ? term + 1 : TMO;
      for (int i = 0; i < len; i++) begin
        e = blank();
        e.ready = 1'b0;
        e.cyc = 1'b1;
        e.stb = (i <= att_stall[a]);
        if (i < att_stall[a]) begin
          e.stall = 1'b1;
          if ($urandom_range(0, 2) == 0) e = noisy(e);
        end else if (i == att_stall[a]) e.stall = 1'b0;
        if (i == term) begin
          case (att_kind[a])
            K_ACK: begin e.ack = 1'b1; e.dat = att_dat[a]; end
            K_ERR: begin e.err = 1'b1; e.ack = att_extra[a]; e.rty = 1'($urandom_range(0, 1)); end
            default: begin e.rty = 1'b1; e.ack = att_extra[a]; end
          endcase
        end
        plan.push_back(e);
      end
      if (term >= TMO) begin
        m_status = 2'b10; done = 1;
      end else if (att_kind[a] == K_ACK) begin
        m_status = 2'b00; m_dat = we ? 32'h0 : att_dat[a]; done = 1;
      end else if (att_kind[a] == K_ERR) begin
        m_status = 2'b01; done = 1;
      end else if (a < MR) begin
        e = blank();
        if ($urandom_range(0, 1) == 1) e = noisy(e);
        plan.push_back(e);
        a++;
      end else begin
        m_status = 2'b11; done = 1;
      end
    end
    for (int r = 0; r <= rdly; r++) begin
      e = blank();
      e.resp  = 1'b1;
      e.ready = (r == rdly);
      if ($urandom_range(0, 2) == 0) e = noisy(e);
      plan.push_back(e);
    end
  endtask

  task automatic drive_slave(input ent_t e);
    wb_stall = e.stall; wb_ack = e.ack; wb_err = e.err; wb_rty = e.rty;
    wb_dat_i = e.dat;   rsp_ready = e.ready;
  endtask

  task automatic set_idle_exp();
    exp_cyc = 0; exp_stb = 0; exp_rv = 0; exp_rdy = 1; exp_busy = 0;
  endtask

  task automatic idle_cycles(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      e = blank();
      if ($urandom_range(0, 1) == 1) e = noisy(e);
      drive_slave(e);
      set_idle_exp();
    end
  endtask

  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int rdly);
    ent_t e;
    build_plan(we, rdly);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    e = blank();
    drive_slave(e);
    set_idle_exp();
    cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
    exp_rdat = m_dat; exp_rstat = m_status;
    stb_phases = 0; cyc_cycles = 0;
    foreach (plan[k]) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we = 1'($urandom_range(0, 1)); cmd_adr = $urandom; cmd_dat = $urandom;
      cmd_sel = 4'($urandom_range(0, 15));
      drive_slave(plan[k]);
      exp_cyc = plan[k].cyc; exp_stb = plan[k].stb; exp_rv = plan[k].resp;
      exp_rdy = 0; exp_busy = 1;
    end
  endtask

  task automatic set_att(input int a, input int st, input int dl, input int kind,
                         input bit extra, input logic [31:0] d);
    att_stall[a] = st; att_delay[a] = dl; att_kind[a] = kind;
    att_extra[a] = extra; att_dat[a] = d;
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 0; wb_ack = 0; wb_err = 0; wb_rty = 0; wb_stall = 0; wb_dat_i = '0;
    prev_stb = 0; stb_phases = 0; cyc_cycles = 0;
    set_idle_exp();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_rsp_status", 32'(rsp_status), 32'h0);
    chk("rst_wb_ctl", 32'({wb_cyc, wb_stb, wb_we, busy}), 32'h0);
    chk("rst_wb_bus", wb_adr | wb_dat_o | 32'(wb_sel), 32'h0);
    chk_en = 1;

    // Read with two stalled strobe cycles, ack with stall release.
    set_att(0, 2, 0, K_ACK, 0, 32'hCAFE0001);
    run_txn(0, 32'h10, 32'h0, 4'hF, 0);
    idle_cycles(1);
    chk("lit_rd_model", m_dat, 32'hCAFE0001);
    chk("lit_rd_dat", obs_dat, 32'hCAFE0001);
    chk("lit_rd_status", 32'(obs_stat), 32'h0);

    set_att(0, 0, 1, K_ACK, 0, 32'hDEADBEEF);
    run_txn(1, 32'h04, 32'h12345678, 4'hF, 1);
    idle_cycles(1);
    chk("lit_wr_dat", obs_dat, 32'h0);
    chk("lit_wr_status", 32'(obs_stat), 32'h0);

    for (int a = 0; a <= MR; a++) set_att(a, 0, 1, K_RTY, 0, 32'h0);
    run_txn(0, 32'h40, 32'h0, 4'h3, 0);
    idle_cycles(1);
    chk("lit_rty_phases", 32'(stb_phases), 32'd4);
    chk("lit_rty_cyc_cycles", 32'(cyc_cycles), 32'd8);
    chk("lit_rty_status", 32'(obs_stat), 32'h3);

    set_att(0, 0, 0, K_NONE, 0, 32'h0);
    run_txn(0, 32'h80, 32'h0, 4'hF, 2);
    idle_cycles(2);
    chk("lit_tmo_cyc_cycles", 32'(cyc_cycles), 32'd8);
    chk("lit_tmo_status", 32'(obs_stat), 32'h2);

    set_att(0, 0, 2, K_ERR, 1, 32'h0);
    run_txn(0, 32'hC0, 32'h0, 4'hF, 5);
    idle_cycles(1);
    chk("lit_err_model", 32'(m_status), 32'h1);
    chk("lit_err_status", 32'(obs_stat), 32'h1);

    // Reset pulsed while waiting in the data phase.
    chk_en = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h20; cmd_sel = 4'hF;
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rty = 0;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("rstx_stb", 32'(wb_stb), 32'h1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstx_data_phase", 32'({wb_cyc, wb_stb}), 32'h2);
    @(posedge clk); #1;
    rst = 0; wb_ack = 1;
    @(negedge clk);
    chk("rstx_cyc_drop", 32'(wb_cyc), 32'h0);
    chk("rstx_no_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    wb_ack = 0;
    @(negedge clk);
    chk("rstx_no_rsp_late", 32'(rsp_valid), 32'h0);
    chk("rstx_ready", 32'(cmd_ready), 32'h1);
    set_idle_exp();
    prev_stb = 0;
    chk_en = 1;
    set_att(0, 1, 1, K_ACK, 0, 32'h55AA0F0F);
    run_txn(0, 32'h24, 32'h0, 4'hF, 0);
    idle_cycles(1);
    chk("rstx_after_dat", obs_dat, 32'h55AA0F0F);

    for (int t = 0; t < 150; t++) begin
      for (int a = 0; a <= MR; a++) begin
        int r;
        r = $urandom_range(0, 9);
        set_att(a, $urandom_range(0, 3), $urandom_range(0, 5),
                (r == 0) ? K_NONE : (r <= 5) ? K_ACK : (r <= 7) ? K_ERR : K_RTY,
                1'($urandom_range(0, 1)), $urandom);
      end
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
